mastermind_codebreaker: RTL and testbench

Automatic codebreaker for the 4-peg, 8-colour Mastermind game. It proposes guesses, accepts red/white feedback from a scoring engine (on-board judge or bench oracle), and stores a guess/feedback history. It then searches the 4096-code space for the next candidate consistent with every past result. It sits on the guess-producing side of the same code/guess/feedback interface as the game datapath: 12-bit packed code, peg i at bits [3i+2:3i], 3-bit red/white counts.

---
 rtl/mastermind_codebreaker_pkg.sv | 11 +
 rtl/mastermind_codebreaker_if.sv | 11 +
 rtl/mastermind_codebreaker_score.sv | 34 +++
 rtl/mastermind_codebreaker.sv | 105 ++++++++++
 tb/tb_mastermind_codebreaker.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mastermind_codebreaker_pkg.sv
// mm_pkg: shared Mastermind widths, codebreaker state encoding and peg extraction.
package mm_pkg;
    localparam int NUM_PEGS = 4;
    localparam int COLOR_W = 3;
    localparam int NUM_COLORS = 8;
    localparam int CODE_W = 12;
    typedef enum logic [1:0] {IDLE, SEARCH, OFFER, DONE} state_e;
    function automatic logic [COLOR_W-1:0] peg(input logic [CODE_W-1:0] code, input int i);
        return code[i*COLOR_W +: COLOR_W];
    endfunction
endpackage

// File: rtl/mastermind_codebreaker_if.sv
// mastermind_codebreaker_if: guess/feedback link between a codebreaker (master) and a judge (slave).
interface mastermind_codebreaker_if;
    import mm_pkg::*;
    logic guess_valid;
    logic [CODE_W-1:0] guess;
    logic fb_valid;
    logic [2:0] fb_red;
    logic [2:0] fb_white;
    modport master(output guess_valid, guess, input fb_valid, fb_red, fb_white);
    modport slave(input guess_valid, guess, output fb_valid, fb_red, fb_white);
endinterface

// File: rtl/mastermind_codebreaker_score.sv
// mastermind_score: combinational red/white scoring of two packed codes.
module mastermind_score
    import mm_pkg::*;
(
    input  logic [CODE_W-1:0] i_a,
    input  logic [CODE_W-1:0] i_b,
    output logic [2:0]        o_red,
    output logic [2:0]        o_white
);
    logic [2:0] w_red;
    logic [2:0] w_common;
    logic [2:0] w_na;
    logic [2:0] w_nb;
    always_comb begin
        w_red = '0;
        w_common = '0;
        w_na = '0;
        w_nb = '0;
        for (int i = 0; i < NUM_PEGS; i++)
            w_red = w_red + 3'(peg(i_a, i) == peg(i_b, i));
        // colour overlap is the per-colour minimum of the two histograms
        for (int c = 0; c < NUM_COLORS; c++) begin
            w_na = '0;
            w_nb = '0;
            for (int i = 0; i < NUM_PEGS; i++) begin
                w_na = w_na + 3'(peg(i_a, i) == COLOR_W'(c));
                w_nb = w_nb + 3'(peg(i_b, i) == COLOR_W'(c));
            end
            w_common = w_common + ((w_na < w_nb) ? w_na : w_nb);
        end
    end
    assign o_red = w_red;
    assign o_white = w_common - w_red;
endmodule

// File: rtl/mastermind_codebreaker.sv
// mastermind_codebreaker: proposes Mastermind guesses, keeping each one consistent with all
// feedback so far by scanning the code space upward from the last offered guess.
module mastermind_codebreaker
    import mm_pkg::*;
#(
    parameter int MAX_GUESSES = 8
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            start,
    mastermind_codebreaker_if.master        bus,
    output logic                            busy,
    output logic                            done,
    output logic                            solved,
    output logic [4:0]                      guess_count
);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_SEARCH = SEARCH;
    localparam logic [1:0] S_OFFER = OFFER;
    localparam logic [1:0] S_DONE = DONE;
    localparam int IW = (MAX_GUESSES > 1) ? $clog2(MAX_GUESSES) : 1;

    logic [1:0]        r_state;
    logic [17:0]       r_hist [MAX_GUESSES];
    logic [4:0]        r_hist_cnt;
    logic [4:0]        r_idx;
    logic [CODE_W-1:0] r_cand;
    logic [CODE_W-1:0] r_guess;
    logic [4:0]        r_count;
    logic              r_solved;
    logic [17:0]       w_entry;
    logic [2:0]        w_red;
    logic [2:0]        w_white;
    logic              w_match;
    logic              w_illegal;
    logic              w_finish;

    assign w_entry = r_hist[r_idx[IW-1:0]];

    mastermind_score u_score (
        .i_a    (r_cand),
        .i_b    (w_entry[17:6]),
        .o_red  (w_red),
        .o_white(w_white)
    );

    assign w_match = {w_red, w_white} == w_entry[5:0];
    assign w_illegal = (bus.fb_red > 3'd4) || ({1'b0, bus.fb_red} + {1'b0, bus.fb_white} > 4'd4)
                     || (bus.fb_red == 3'd3 && bus.fb_white == 3'd1);
    assign w_finish = w_illegal || bus.fb_red == 3'd4 || r_count == 5'(MAX_GUESSES);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_hist_cnt <= '0;
            r_idx <= '0;
            r_cand <= '0;
            r_guess <= '0;
            r_count <= '0;
            r_solved <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: if (start) begin
                    r_state <= S_SEARCH;
                    r_hist_cnt <= '0;
                    r_cand <= '0;
                    r_idx <= '0;
                    r_count <= '0;
                    r_solved <= 1'b0;
                end
                S_SEARCH: if (r_idx == r_hist_cnt) begin
                    r_guess <= r_cand;
                    r_count <= r_count + 5'd1;
                    r_state <= S_OFFER;
                end else if (w_match) begin
                    r_idx <= r_idx + 5'd1;
                end else begin
                    r_idx <= '0;
                    r_cand <= r_cand + 1'b1;
                    if (&r_cand) r_state <= S_DONE;
                end
                S_OFFER: if (bus.fb_valid) begin
                    if (w_finish) begin
                        r_state <= S_DONE;
                        r_solved <= !w_illegal && bus.fb_red == 3'd4;
                    end else begin
                        r_hist[r_hist_cnt[IW-1:0]] <= {r_guess, bus.fb_red, bus.fb_white};
                        r_hist_cnt <= r_hist_cnt + 5'd1;
                        r_cand <= r_guess + 1'b1;
                        r_idx <= '0;
                        r_state <= S_SEARCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.guess_valid = r_state == S_OFFER;
    assign bus.guess = r_guess;
    assign busy = r_state == S_SEARCH || r_state == S_OFFER;
    assign done = r_state == S_DONE;
    assign solved = r_solved;
    assign guess_count = r_count;
endmodule

// File: tb/tb_mastermind_codebreaker.sv
// tb_mastermind_codebreaker: directed vector table, hand sequences and a small secret-code
// oracle against two codebreakers (guess budgets 8 and 16) sharing stimulus.
module tb_mastermind_codebreaker;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic start = 1'b0;
    logic busy8, done8, solved8, busy16, done16, solved16;
    logic [4:0] cnt8, cnt16;
    logic [11:0] sc_a = '0, sc_b = '0;
    logic [2:0] sc_red, sc_white;
    int n_checks = 0;
    int n_fail = 0;

    mastermind_codebreaker_if if8();
    mastermind_codebreaker_if if16();
    assign if16.fb_valid = if8.fb_valid;
    assign if16.fb_red = if8.fb_red;
    assign if16.fb_white = if8.fb_white;

    mastermind_codebreaker #(.MAX_GUESSES(8)) dut (
        .clk(clk), .resetn(resetn), .start(start), .bus(if8),
        .busy(busy8), .done(done8), .solved(solved8), .guess_count(cnt8)
    );
    mastermind_codebreaker #(.MAX_GUESSES(16)) dut16 (
        .clk(clk), .resetn(resetn), .start(start), .bus(if16),
        .busy(busy16), .done(done16), .solved(solved16), .guess_count(cnt16)
    );
    mastermind_score u_oracle (.i_a(sc_a), .i_b(sc_b), .o_red(sc_red), .o_white(sc_white));

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] r;
        logic [2:0] w;
        logic done;
        logic solved;
        logic [11:0] g;
        logic [4:0] cnt;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic start_game();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feedback(input logic [2:0] r, input logic [2:0] w);
        if8.fb_valid = 1'b1;
        if8.fb_red = r;
        if8.fb_white = w;
        tick();
        if8.fb_valid = 1'b0;
    endtask

    task automatic wait_dut(input bit d16, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            if (d16 ? (if16.guess_valid || done16) : (if8.guess_valid || done8)) ok = 1'b1;
            else tick();
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_timeout: no offer or done within 20000 cycles (dut16=%0d)", d16);
        end
    endtask

    // Independent scorer: classic mark-and-match instead of colour histograms.
    function automatic logic [5:0] ref_score(input logic [11:0] a, input logic [11:0] b);
        int red, white;
        bit ua[4], ub[4];
        bit found;
        red = 0;
        white = 0;
        for (int i = 0; i < 4; i++) begin
            ua[i] = a[3*i +: 3] == b[3*i +: 3];
            ub[i] = ua[i];
            if (ua[i]) red++;
        end
        for (int i = 0; i < 4; i++) begin
            found = 1'b0;
            for (int j = 0; j < 4; j++)
                if (!ua[i] && !ub[j] && !found && a[3*i +: 3] == b[3*j +: 3]) begin
                    ub[j] = 1'b1;
                    found = 1'b1;
                    white++;
                end
        end
        return {3'(red), 3'(white)};
    endfunction

    initial begin
        vec_t vecs[10];
        bit ok;
        logic [11:0] hg[16];
        logic [5:0] hfb[16];
        logic [11:0] secret;
        logic [11:0] g;
        bit good;
        int n;
        if8.fb_valid = 1'b0;
        if8.fb_red = '0;
        if8.fb_white = '0;
        vecs[0] = '{3'd4, 3'd0, 1'b1, 1'b1, 12'h000, 5'd1};
        vecs[1] = '{3'd3, 3'd0, 1'b0, 1'b0, 12'h001, 5'd2};
        vecs[2] = '{3'd2, 3'd0, 1'b0, 1'b0, 12'h009, 5'd2};
        vecs[3] = '{3'd1, 3'd0, 1'b0, 1'b0, 12'h049, 5'd2};
        vecs[4] = '{3'd0, 3'd0, 1'b0, 1'b0, 12'h249, 5'd2};
        vecs[5] = '{3'd5, 3'd0, 1'b1, 1'b0, 12'h000, 5'd1};
        vecs[6] = '{3'd3, 3'd1, 1'b1, 1'b0, 12'h000, 5'd1};
        vecs[7] = '{3'd2, 3'd3, 1'b1, 1'b0, 12'h000, 5'd1};
        vecs[8] = '{3'd4, 3'd1, 1'b1, 1'b0, 12'h000, 5'd1};
        vecs[9] = '{3'd0, 3'd1, 1'b1, 1'b0, 12'h000, 5'd1};

        do_reset();
        check("rst_guess_valid", if8.guess_valid, 0);
        check("rst_guess", if8.guess, 0);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_solved", solved8, 0);
        check("rst_count", cnt8, 0);

        // Secret 0x000 with exact first-guess latency, then restart from DONE.
        start_game();
        check("lat_busy_n1", busy8, 1);
        check("lat_gv_n1", if8.guess_valid, 0);
        tick();
        check("lat_gv_n2", if8.guess_valid, 1);
        check("lat_guess_n2", if8.guess, 12'h000);
        feedback(3'd4, 3'd0);
        check("s0_gv_drop", if8.guess_valid, 0);
        check("s0_done", done8, 1);
        check("s0_solved", solved8, 1);
        check("s0_count", cnt8, 1);
        start_game();
        check("restart_done_drop", done8, 0);
        check("restart_busy", busy8, 1);
        check("restart_count", cnt8, 0);

        for (int k = 0; k < 10; k++) begin
            do_reset();
            start_game();
            wait_dut(1'b0, ok);
            check($sformatf("vec%0d_first", k), if8.guess, 12'h000);
            feedback(vecs[k].r, vecs[k].w);
            wait_dut(1'b0, ok);
            check($sformatf("vec%0d_done", k), done8, vecs[k].done);
            check($sformatf("vec%0d_solved", k), solved8, vecs[k].solved);
            check($sformatf("vec%0d_guess", k), if8.guess, vecs[k].g);
            check($sformatf("vec%0d_count", k), cnt8, vecs[k].cnt);
        end

        // Secret 0x001.
        do_reset();
        start_game();
        wait_dut(1'b0, ok);
        feedback(3'd3, 3'd0);
        wait_dut(1'b0, ok);
        check("s1_guess2", if8.guess, 12'h001);
        feedback(3'd4, 3'd0);
        check("s1_done", done8, 1);
        check("s1_solved", solved8, 1);
        check("s1_count", cnt8, 2);

        // 0x249 answered with illegal red=3 white=2; guess holds in DONE.
        do_reset();
        start_game();
        wait_dut(1'b0, ok);
        feedback(3'd0, 3'd0);
        wait_dut(1'b0, ok);
        check("ill_guess2", if8.guess, 12'h249);
        feedback(3'd3, 3'd2);
        check("ill_done", done8, 1);
        check("ill_solved", solved8, 0);
        check("ill_hold_guess", if8.guess, 12'h249);

        // All-zero feedback: monochrome guesses; budget 8 stops, budget 16 exhausts the space.
        do_reset();
        start_game();
        for (int k = 0; k < 8; k++) begin
            wait_dut(1'b0, ok);
            check($sformatf("mono%0d_guess8", k), if8.guess, 12'(k * 12'h249));
            check($sformatf("mono%0d_guess16", k), if16.guess, 12'(k * 12'h249));
            feedback(3'd0, 3'd0);
        end
        check("mono_done8", done8, 1);
        check("mono_solved8", solved8, 0);
        check("mono_count8", cnt8, 8);
        check("mono_busy16", busy16, 1);
        wait_dut(1'b1, ok);
        check("mono_done16", done16, 1);
        check("mono_solved16", solved16, 0);
        check("mono_count16", cnt16, 8);

        // Ignored inputs during SEARCH and OFFER, then reset while offering.
        do_reset();
        start_game();
        wait_dut(1'b0, ok);
        feedback(3'd0, 3'd0);
        if8.fb_valid = 1'b1;
        if8.fb_red = 3'd4;
        start = 1'b1;
        tick();
        if8.fb_valid = 1'b0;
        start = 1'b0;
        check("ign_search_busy", busy8, 1);
        check("ign_search_done", done8, 0);
        wait_dut(1'b0, ok);
        check("ign_search_guess", if8.guess, 12'h249);
        check("ign_search_count", cnt8, 2);
        start_game();
        check("ign_offer_gv", if8.guess_valid, 1);
        check("ign_offer_guess", if8.guess, 12'h249);
        check("ign_offer_count", cnt8, 2);
        resetn = 1'b0;
        tick();
        check("midrst_gv", if8.guess_valid, 0);
        check("midrst_guess", if8.guess, 0);
        check("midrst_busy", busy8, 0);
        check("midrst_done", done8, 0);
        check("midrst_solved", solved8, 0);
        check("midrst_count", cnt8, 0);
        resetn = 1'b1;

        // Oracle games on random secrets.
        do_reset();
        for (int gm = 0; gm < 8; gm++) begin
            secret = 12'($urandom_range(0, 4095));
            n = 0;
            ok = 1'b1;
            start_game();
            while (ok) begin
                wait_dut(1'b0, ok);
                if (ok && !done8) begin
                    g = if8.guess;
                    good = 1'b1;
                    for (int j = 0; j < n; j++) if (ref_score(g, hg[j]) != hfb[j]) good = 1'b0;
                    check($sformatf("g%0d_consistent_%0h", gm, g), good, 1);
                    good = 1'b1;
                    for (int j = 0; j < n; j++) if (hg[j] == g) good = 1'b0;
                    check($sformatf("g%0d_norepeat_%0h", gm, g), good, 1);
                    sc_a = secret;
                    sc_b = g;
                    #1;
                    check($sformatf("g%0d_scorer_%0h", gm, g), {sc_red, sc_white}, ref_score(secret, g));
                    hg[n] = g;
                    hfb[n] = {sc_red, sc_white};
                    n++;
                    feedback(sc_red, sc_white);
                end else begin
                    ok = 1'b0;
                end
            end
            check($sformatf("g%0d_count_%0h", gm, secret), cnt8, 5'(n));
            good = solved8 ? (n > 0 && hg[n-1] == secret) : (cnt8 == 5'd8);
            check($sformatf("g%0d_outcome_%0h", gm, secret), good, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
